// File: rtl/lr_parser_pkg.sv
// rtl/lr_parser_pkg.sv - Shared encodings for the LR(1) shift/reduce engine
package lr_parser_pkg;

  typedef enum logic [1:0] {
    ACT_ERROR  = 2'd0,
    ACT_SHIFT  = 2'd1,
    ACT_REDUCE = 2'd2,
    ACT_ACCEPT = 2'd3
  } act_type_e;

  typedef enum logic [2:0] {
    S_INIT,
    S_WAIT,
    S_MOVE,
    S_SHIFT,
    S_POP,
    S_GOTO,
    S_ACCEPT,
    S_ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_NO_ACTION = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd3;

  localparam logic [1:0] SEL_ACTION  = 2'd0;
  localparam logic [1:0] SEL_RHS_LEN = 2'd1;
  localparam logic [1:0] SEL_GOTO    = 2'd2;
  localparam logic [1:0] SEL_RSVD    = 2'd3;

  function automatic int lr_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lr_state_stack.sv
// rtl/lr_state_stack.sv - Parser state stack with combinational top-of-stack read
module lr_state_stack
  import lr_parser_pkg::*;
#(
  parameter int W     = 3,
  parameter int DEPTH = 1024
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             push_data,
  output logic [W-1:0]             top,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  sp;
  logic [AW-1:0] top_idx;

  assign top_idx = AW'(sp - (AW+1)'(1));
  assign top     = mem[top_idx];
  assign full    = (sp == (AW+1)'(DEPTH));
  assign empty   = (sp == '0);
  assign count   = sp;

  // Storage is never reset; only the pointer defines what is live.
  always_ff @(posedge CLK) begin
    if (push && !full && !clr)
      mem[sp[AW-1:0]] <= push_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      sp <= '0;
    else if (clr)
      sp <= '0;
    else if (push && !full)
      sp <= sp + (AW+1)'(1);
    else if (pop && !empty)
      sp <= sp - (AW+1)'(1);
  end

endmodule

// File: rtl/lr_parser_engine.sv
// rtl/lr_parser_engine.sv - Table-driven LR(1) shift/reduce engine with run-time loaded tables
module lr_parser_engine
  import lr_parser_pkg::*;
#(
  parameter int STATE_W = 3,
  parameter int TOKEN_W = 2,
  parameter int RULE_W  = 2,
  parameter int LEN_W   = 4,
  parameter int DEPTH   = 1024
) (
  input  logic                                     CLK,
  input  logic                                     RST_N,
  input  logic                                     CLR,
  input  logic                                     TBL_WE,
  input  logic [1:0]                               TBL_SEL,
  input  logic [STATE_W+lr_max(TOKEN_W,RULE_W)-1:0] TBL_ADDR,
  input  logic [lr_max(STATE_W,RULE_W)+1:0]        TBL_DATA,
  input  logic                                     I_VALID,
  input  logic [TOKEN_W-1:0]                       I_TOKEN,
  output logic                                     I_READY,
  output logic                                     O_VALID,
  output logic [RULE_W-1:0]                        O_RULE,
  output logic                                     O_ACCEPT,
  output logic                                     O_ERROR,
  output logic [1:0]                               O_ERRCODE,
  output logic                                     BUSY
);

  localparam int VAL_W  = lr_max(STATE_W, RULE_W);
  localparam int COL_W  = lr_max(TOKEN_W, RULE_W);
  localparam int ADDR_W = STATE_W + COL_W;
  localparam int DATA_W = VAL_W + 2;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0]  act_mem  [2**(STATE_W+TOKEN_W)];
  logic [STATE_W-1:0] goto_mem [2**(STATE_W+RULE_W)];
  logic [LEN_W-1:0]   len_mem  [2**RULE_W];

  state_e state, state_nxt;
  logic [TOKEN_W-1:0] tok_q;
  logic [VAL_W-1:0]   val_q;
  logic [LEN_W-1:0]   cnt_q;
  logic               ready_q, o_valid_q, accept_q, error_q;
  logic [RULE_W-1:0]  o_rule_q;
  logic [1:0]         errcode_q;

  logic               push, pop;
  logic [STATE_W-1:0] push_data, stk_top;
  logic               stk_full, stk_empty;
  logic [CNT_W-1:0]   stk_count;

  logic               load_tok, load_act, load_cnt, dec_cnt;
  logic               err_set, acc_set, valid_set;
  logic [1:0]         err_nxt;

  logic [STATE_W-1:0] tbl_row;
  logic [COL_W-1:0]   tbl_col;
  logic               tbl_wr_en;
  logic [DATA_W-1:0]  act_word;
  act_type_e          act_type;
  logic [VAL_W-1:0]   act_val;
  logic [LEN_W-1:0]   rhs_len;
  logic [RULE_W-1:0]  rule_q;
  logic [STATE_W-1:0] goto_state;

  lr_state_stack #(.W(STATE_W), .DEPTH(DEPTH)) u_stack (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .clr       (CLR),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty),
    .count     (stk_count)
  );

  assign BUSY = state inside {S_MOVE, S_SHIFT, S_POP, S_GOTO};

  assign tbl_row = TBL_ADDR[ADDR_W-1:COL_W];
  assign tbl_col = TBL_ADDR[COL_W-1:0];
  // A restart may reprogram tables in the same cycle even if it aborts a busy step.
  assign tbl_wr_en = TBL_WE && (!BUSY || CLR);

  always_ff @(posedge CLK) begin
    if (tbl_wr_en && TBL_SEL == SEL_ACTION)
      act_mem[{tbl_row, tbl_col[TOKEN_W-1:0]}] <= TBL_DATA;
    if (tbl_wr_en && TBL_SEL == SEL_RHS_LEN)
      len_mem[tbl_col[RULE_W-1:0]] <= LEN_W'(TBL_DATA);
    if (tbl_wr_en && TBL_SEL == SEL_GOTO)
      goto_mem[{tbl_row, tbl_col[RULE_W-1:0]}] <= TBL_DATA[STATE_W-1:0];
  end

  assign act_word   = act_mem[{stk_top, tok_q}];
  assign act_type   = act_type_e'(act_word[DATA_W-1:VAL_W]);
  assign act_val    = act_word[VAL_W-1:0];
  assign rhs_len    = len_mem[act_val[RULE_W-1:0]];
  assign rule_q     = val_q[RULE_W-1:0];
  assign goto_state = goto_mem[{stk_top, rule_q}];

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = '0;
    load_tok  = 1'b0;
    load_act  = 1'b0;
    load_cnt  = 1'b0;
    dec_cnt   = 1'b0;
    err_set   = 1'b0;
    err_nxt   = ERR_NONE;
    acc_set   = 1'b0;
    valid_set = 1'b0;
    case (state)
      S_INIT: begin
        push      = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (I_VALID && ready_q) begin
          load_tok  = 1'b1;
          state_nxt = S_MOVE;
        end
      end
      S_MOVE: begin
        case (act_type)
          ACT_SHIFT: begin
            load_act  = 1'b1;
            state_nxt = S_SHIFT;
          end
          ACT_REDUCE: begin
            load_act  = 1'b1;
            load_cnt  = 1'b1;
            state_nxt = (rhs_len == '0) ? S_GOTO : S_POP;
          end
          ACT_ACCEPT: begin
            acc_set   = 1'b1;
            state_nxt = S_ACCEPT;
          end
          default: begin
            err_set   = 1'b1;
            err_nxt   = ERR_NO_ACTION;
            state_nxt = S_ERROR;
          end
        endcase
      end
      S_SHIFT: begin
        if (stk_full) begin
          err_set   = 1'b1;
          err_nxt   = ERR_OVERFLOW;
          state_nxt = S_ERROR;
        end else begin
          push      = 1'b1;
          push_data = val_q[STATE_W-1:0];
          state_nxt = S_WAIT;
        end
      end
      S_POP: begin
        // The bottom entry (state 0) is never popped.
        if (stk_empty || stk_count == CNT_W'(1)) begin
          err_set   = 1'b1;
          err_nxt   = ERR_UNDERFLOW;
          state_nxt = S_ERROR;
        end else begin
          pop     = 1'b1;
          dec_cnt = 1'b1;
          if (cnt_q == LEN_W'(1))
            state_nxt = S_GOTO;
        end
      end
      S_GOTO: begin
        if (stk_full) begin
          err_set   = 1'b1;
          err_nxt   = ERR_OVERFLOW;
          state_nxt = S_ERROR;
        end else begin
          push      = 1'b1;
          push_data = goto_state;
          valid_set = 1'b1;
          state_nxt = S_MOVE;
        end
      end
      default: ;
    endcase
    if (CLR) begin
      state_nxt = S_INIT;
      push      = 1'b0;
      pop       = 1'b0;
      load_tok  = 1'b0;
      err_set   = 1'b0;
      acc_set   = 1'b0;
      valid_set = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_INIT;
      tok_q     <= '0;
      val_q     <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      o_valid_q <= 1'b0;
      o_rule_q  <= '0;
      accept_q  <= 1'b0;
      error_q   <= 1'b0;
      errcode_q <= ERR_NONE;
    end else begin
      state     <= state_nxt;
      ready_q   <= (state_nxt == S_WAIT);
      o_valid_q <= valid_set;
      o_rule_q  <= valid_set ? rule_q : '0;
      if (load_tok) tok_q <= I_TOKEN;
      if (load_act) val_q <= act_val;
      if (load_cnt)     cnt_q <= rhs_len;
      else if (dec_cnt) cnt_q <= cnt_q - LEN_W'(1);
      if (CLR) begin
        accept_q  <= 1'b0;
        error_q   <= 1'b0;
        errcode_q <= ERR_NONE;
      end else begin
        if (acc_set) accept_q <= 1'b1;
        if (err_set) begin
          error_q   <= 1'b1;
          errcode_q <= err_nxt;
        end
      end
    end
  end

  assign I_READY   = ready_q;
  assign O_VALID   = o_valid_q;
  assign O_RULE    = o_rule_q;
  assign O_ACCEPT  = accept_q;
  assign O_ERROR   = error_q;
  assign O_ERRCODE = errcode_q;

endmodule

// File: tb/tb_lr_parser_engine.sv
// tb/tb_lr_parser_engine.sv - Directed bench for lr_parser_engine on the expression grammar
module tb_lr_parser_engine;

  localparam logic [1:0] NUM = 2'd0, PLUS = 2'd1, STAR = 2'd2, ENDM = 2'd3;
  localparam logic [4:0] ACC = 5'b11000;

  logic       CLK = 1'b0;
  logic       RST_N, CLR, TBL_WE, I_VALID;
  logic [1:0] TBL_SEL, I_TOKEN;
  logic [4:0] TBL_ADDR, TBL_DATA;
  logic       I_READY, O_VALID, O_ACCEPT, O_ERROR, BUSY;
  logic [1:0] O_RULE, O_ERRCODE;

  int total = 0, passed = 0, hs_cnt = 0, lat;
  logic [1:0] rules [$];
  logic [1:0] exp_t1 [4] = '{2'd3, 2'd1, 2'd3, 2'd0};

  lr_parser_engine #(
    .STATE_W(3), .TOKEN_W(2), .RULE_W(2), .LEN_W(4), .DEPTH(4)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .TBL_WE(TBL_WE), .TBL_SEL(TBL_SEL),
    .TBL_ADDR(TBL_ADDR), .TBL_DATA(TBL_DATA), .I_VALID(I_VALID), .I_TOKEN(I_TOKEN),
    .I_READY(I_READY), .O_VALID(O_VALID), .O_RULE(O_RULE), .O_ACCEPT(O_ACCEPT),
    .O_ERROR(O_ERROR), .O_ERRCODE(O_ERRCODE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (O_VALID) rules.push_back(O_RULE);
  always @(posedge CLK) if (RST_N && I_VALID && I_READY) hs_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic [4:0] sh(input logic [2:0] s);
    return {2'b01, s};
  endfunction

  function automatic logic [4:0] rd(input logic [1:0] r);
    return {2'b10, 1'b0, r};
  endfunction

  task automatic wr(input logic [1:0] sel, input logic [2:0] row, input logic [1:0] col,
                    input logic [4:0] data);
    TBL_SEL = sel; TBL_ADDR = {row, col}; TBL_DATA = data; TBL_WE = 1'b1;
    @(posedge CLK); #1 TBL_WE = 1'b0;
  endtask

  task automatic clr_pulse();
    CLR = 1'b1;
    @(posedge CLK); #1 CLR = 1'b0;
  endtask

  task automatic send_tok(input logic [1:0] t, output int l);
    I_VALID = 1'b1; I_TOKEN = t; l = 0;
    do begin @(negedge CLK); l++; end while (!I_READY && l < 60);
    chk("tok_ready", I_READY, 1);
    if (I_READY) begin @(posedge CLK); #1; end
  endtask

  task automatic wait_end();
    for (int i = 0; i < 40 && !(O_ACCEPT || O_ERROR); i++) @(negedge CLK);
    I_VALID = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin
    RST_N = 1'b0; CLR = 1'b0; TBL_WE = 1'b0; TBL_SEL = '0; TBL_ADDR = '0; TBL_DATA = '0;
    I_VALID = 1'b0; I_TOKEN = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_outputs", {I_READY, O_VALID, O_RULE, O_ACCEPT, O_ERROR, O_ERRCODE, BUSY}, 0);
    @(negedge CLK) RST_N = 1'b1;
    chk("rst_release_ready", I_READY, 0);
    @(posedge CLK); #1;
    chk("init_ready", I_READY, 1);

    // Expression grammar: 0:E->E+T 1:E->T 2:T->T*num 3:T->num
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++) wr(2'd0, 3'(r), 2'(c), 5'd0);
    wr(0, 0, NUM, sh(3));
    wr(0, 1, PLUS, sh(4));  wr(0, 1, ENDM, ACC);
    wr(0, 2, PLUS, rd(1));  wr(0, 2, STAR, sh(5));  wr(0, 2, ENDM, rd(1));
    wr(0, 3, PLUS, rd(3));  wr(0, 3, STAR, rd(3));  wr(0, 3, ENDM, rd(3));
    wr(0, 4, NUM, sh(3));
    wr(0, 5, NUM, sh(7));
    wr(0, 6, PLUS, rd(0));  wr(0, 6, STAR, sh(5));  wr(0, 6, ENDM, rd(0));
    wr(0, 7, PLUS, rd(2));  wr(0, 7, STAR, rd(2));  wr(0, 7, ENDM, rd(2));
    wr(2, 0, 0, 5'd1); wr(2, 0, 1, 5'd1); wr(2, 0, 2, 5'd2); wr(2, 0, 3, 5'd2);
    wr(2, 4, 2, 5'd6); wr(2, 4, 3, 5'd6);
    wr(1, 0, 0, 5'd3); wr(1, 0, 1, 5'd1); wr(1, 0, 2, 5'd3); wr(1, 0, 3, 5'd1);

    // num + num $ with I_VALID held high throughout
    rules.delete(); hs_cnt = 0;
    send_tok(NUM, lat);
    send_tok(PLUS, lat);
    chk("t4_shift_latency", lat, 3);
    send_tok(NUM, lat);
    chk("t1_reduce_latency", lat, 9);
    send_tok(ENDM, lat);
    chk("t4_shift_latency2", lat, 3);
    wait_end();
    chk("t1_nrules", rules.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t1_rule%0d", i), rules[i], exp_t1[i]);
    chk("t1_accept", O_ACCEPT, 1);
    chk("t1_error", O_ERROR, 0);
    chk("t1_orule_idle", O_RULE, 0);
    chk("t4_handshakes", hs_cnt, 4);

    // num num -> no action
    clr_pulse();
    chk("clr_accept_cleared", O_ACCEPT, 0);
    rules.delete();
    send_tok(NUM, lat);
    send_tok(NUM, lat);
    wait_end();
    repeat (3) @(posedge CLK);
    #1;
    chk("t2_error", O_ERROR, 1);
    chk("t2_errcode", O_ERRCODE, 1);
    chk("t2_ready_low", I_READY, 0);
    chk("t2_accept", O_ACCEPT, 0);
    chk("t2_nrules", rules.size(), 0);

    // Chained shifts on a 4-deep stack -> overflow on the fourth token
    clr_pulse();
    wr(0, 3, NUM, sh(3));
    for (int i = 0; i < 4; i++) send_tok(NUM, lat);
    wait_end();
    chk("t3_error", O_ERROR, 1);
    chk("t3_errcode", O_ERRCODE, 2);
    chk("t3_busy", BUSY, 0);
    wr(0, 3, NUM, 5'd0);

    // Reduce longer than the stack -> underflow, no rule emitted
    clr_pulse();
    wr(0, 0, PLUS, rd(0));
    rules.delete();
    send_tok(PLUS, lat);
    wait_end();
    chk("uf_errcode", O_ERRCODE, 3);
    chk("uf_nrules", rules.size(), 0);
    wr(0, 0, PLUS, 5'd0);

    // Async reset while popping
    clr_pulse();
    rules.delete();
    send_tok(NUM, lat);
    send_tok(PLUS, lat);
    @(posedge CLK); #1;
    chk("t5_busy_in_pop", BUSY, 1);
    RST_N = 1'b0;
    #1;
    chk("t5_rst_outputs", {I_READY, O_VALID, O_RULE, O_ACCEPT, O_ERROR, O_ERRCODE, BUSY}, 0);
    I_VALID = 1'b0;
    @(negedge CLK) RST_N = 1'b1;
    chk("t5_release_ready", I_READY, 0);
    chk("t5_nrules", rules.size(), 0);
    @(posedge CLK); #1;
    chk("t5_ready_after", I_READY, 1);

    // Table write while busy must be ignored (would break the accept entry)
    rules.delete();
    send_tok(NUM, lat);
    send_tok(PLUS, lat);
    wr(0, 1, ENDM, 5'd0);
    send_tok(NUM, lat);
    send_tok(ENDM, lat);
    wait_end();
    chk("t6_busy_write_accept", O_ACCEPT, 1);
    chk("t6_busy_write_error", O_ERROR, 0);
    chk("t6_nrules", rules.size(), 4);

    // CLR and table write in the same cycle: '*' in state 0 now accepts
    CLR = 1'b1;
    wr(0, 0, STAR, ACC);
    CLR = 1'b0;
    chk("t6_clr_accept", O_ACCEPT, 0);
    send_tok(STAR, lat);
    wait_end();
    chk("t6_star_accept", O_ACCEPT, 1);

    // Fresh parse after CLR: num $
    clr_pulse();
    rules.delete();
    send_tok(NUM, lat);
    send_tok(ENDM, lat);
    wait_end();
    chk("t6_new_accept", O_ACCEPT, 1);
    chk("t6_new_nrules", rules.size(), 2);
    chk("t6_new_rule0", rules[0], 3);
    chk("t6_new_rule1", rules[1], 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
